// File: rtl/gnss_pkg.sv
// Shared types and default sizing for the GNSS front-end capture path.
package gnss_pkg;

    typedef struct packed {
        logic sign;
        logic mag;
    } fe_sample_t;

    localparam int DEFAULT_SAMPLES_PER_WORD = 8;
    localparam int DEFAULT_FIFO_DEPTH       = 16;

endpackage

// File: rtl/gnss_sync_fifo.sv
// Generic synchronous show-ahead FIFO with a level output; head is visible whenever head_valid is high.
module gnss_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     head_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             rd_en;
    logic             wr_en;

    assign level      = wptr - rptr;
    assign full       = (level == (AW+1)'(DEPTH));
    assign head_valid = (level != '0);
    assign head_data  = head_valid ? mem[rptr[AW-1:0]] : '0;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign rd_en = pop && head_valid;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + (AW+1)'(1);
            if (rd_en) rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/gnss_fe_sample_capture.sv
// Synchronises the RF front-end sample stream into sys_clk, packs samples into words and buffers them.
// Defining GNSS_FE_OVF_COUNT_EN adds a saturating dropped-word counter on ovf_count.
module gnss_fe_sample_capture
    import gnss_pkg::*;
#(
    parameter int SAMPLES_PER_WORD = DEFAULT_SAMPLES_PER_WORD,
    parameter int FIFO_DEPTH       = DEFAULT_FIFO_DEPTH
) (
    input  logic                            sys_clk,
    input  logic                            rst,
    input  logic                            fe_clk,
    input  logic                            fe_sign,
    input  logic                            fe_mag,
    input  logic                            enable,
    input  logic                            clear_ovf,
    output logic [2*SAMPLES_PER_WORD-1:0]   word_data,
    output logic                            word_valid,
    input  logic                            word_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
`ifdef GNSS_FE_OVF_COUNT_EN
    output logic                            overflow,
    output logic [15:0]                     ovf_count
`else
    output logic                            overflow
`endif
);

    localparam int WORD_W = 2 * SAMPLES_PER_WORD;
    localparam int IDX_W  = $clog2(SAMPLES_PER_WORD);

    logic clk_s1, clk_s2, clk_s3;
    logic sign_s1, sign_s2;
    logic mag_s1, mag_s2;

    // Data rides the same depth as fe_clk; it moved on the falling edge, so it is settled here.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            {clk_s1, clk_s2, clk_s3} <= '0;
            {sign_s1, sign_s2}       <= '0;
            {mag_s1, mag_s2}         <= '0;
        end else begin
            {clk_s1, clk_s2, clk_s3} <= {fe_clk, clk_s1, clk_s2};
            {sign_s1, sign_s2}       <= {fe_sign, sign_s1};
            {mag_s1, mag_s2}         <= {fe_mag, mag_s1};
        end
    end

    fe_sample_t             sample;
    logic                   capture;
    logic                   last;
    logic [IDX_W-1:0]       idx;
    logic [WORD_W-1:0]      pack_reg;
    logic [WORD_W-1:0]      pack_next;

    assign sample  = '{sign: sign_s2, mag: mag_s2};
    assign capture = enable && clk_s2 && !clk_s3;
    assign last    = (idx == IDX_W'(SAMPLES_PER_WORD - 1));

    always_comb begin
        pack_next = pack_reg;
        pack_next[2*idx +: 2] = sample;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            pack_reg <= '0;
        end else if (!enable) begin
            idx <= '0;
        end else if (capture) begin
            pack_reg <= pack_next;
            idx      <= last ? '0 : idx + IDX_W'(1);
        end
    end

    logic push;
    logic pop;
    logic full;
    logic drop;

    assign push = capture && last;
    assign pop  = word_valid && word_ready;
    assign drop = push && full && !pop;

    gnss_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (sys_clk),
        .rst        (rst),
        .push       (push),
        .push_data  (pack_next),
        .pop        (pop),
        .head_data  (word_data),
        .head_valid (word_valid),
        .full       (full),
        .level      (fifo_level)
    );

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)            overflow <= 1'b0;
        else if (drop)      overflow <= 1'b1;
        else if (clear_ovf) overflow <= 1'b0;
    end

`ifdef GNSS_FE_OVF_COUNT_EN
    // A drop coinciding with a clear restarts the count at one.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            ovf_count <= 16'd0;
        else if (clear_ovf)
            ovf_count <= drop ? 16'd1 : 16'd0;
        else if (drop && ovf_count != 16'hFFFF)
            ovf_count <= ovf_count + 16'd1;
    end
`endif

endmodule
